// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the parametrised synchronous FIFO.
//   DEF_WIDTH / DEF_DEPTH : default word width and entry count
//   cnt_width()           : occupancy counter width for a given depth
//                           (must hold 0..DEPTH inclusive)
//   def_ptr_t / def_cnt_t : pointer and count types for the default depth
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 32;

    // One bit wider than the address so that a completely full FIFO
    // (count == DEPTH) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
    localparam int DEF_CNT_W  = cnt_width(DEF_DEPTH);

    typedef logic [DEF_ADDR_W-1:0] def_ptr_t;
    typedef logic [DEF_CNT_W-1:0]  def_cnt_t;

endpackage

// File: rtl/fifo_ram_2p.sv
// ---------------------------------------------------------------------------
// fifo_ram_2p
// Storage array for sync_fifo_param: one synchronous write port and one
// read port. Array contents are never cleared.
//
// Build option: SYNC_FIFO_FWFT_EN
//   undefined : read port is registered; rdata updates one cycle after re,
//               holds otherwise, cleared by reset
//   defined   : read port is asynchronous; rdata = mem[raddr] at all times
//
// Ports
//   clk    input            clock
//   reset  input            synchronous active-high reset (read register)
//   we     input            write enable
//   waddr  input  ADDR_W    write address
//   wdata  input  WIDTH     write data
//   re     input            read enable (registered mode only)
//   raddr  input  ADDR_W    read address
//   rdata  output WIDTH     read data
// ---------------------------------------------------------------------------
module fifo_ram_2p #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented combinationally; reset and re have no effect here.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = reset ^ re;
    assign rdata          = mem_q[raddr];
`else
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with simultaneous read/write, occupancy
// count, almost-full/almost-empty thresholds, overflow/underflow pulses and
// a read-valid strobe.
//
// Build option: SYNC_FIFO_FWFT_EN
//   undefined : registered read, data_out valid one cycle after an accepted
//               read (data_valid pulses), held otherwise
//   defined   : first-word-fall-through, data_out shows the head word
//               whenever not empty (0 when empty), data_valid = !empty
//
// Ports
//   clk           input            clock, rising edge
//   reset         input            synchronous active-high reset
//   write         input            write request
//   read          input            read request
//   data_in       input  WIDTH     write data
//   data_out      output WIDTH     read data
//   data_valid    output           data_out holds a freshly read word
//   empty         output           counter == 0
//   full          output           counter == DEPTH
//   almost_empty  output           counter <= AE_THRESH
//   almost_full   output           counter >= AF_THRESH
//   overflow      output           1-cycle pulse after write while full
//   underflow     output           1-cycle pulse after read while empty
//   counter       output  CNT_W    occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        write,
    input  logic                        read,
    input  logic [WIDTH-1:0]            data_in,
    output logic [WIDTH-1:0]            data_out,
    output logic                        data_valid,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_empty,
    output logic                        almost_full,
    output logic                        overflow,
    output logic                        underflow,
    output logic [cnt_width(DEPTH)-1:0] counter
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0]  CNT_AE   = CNT_W'(AE_THRESH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;

    logic              wr_acc;
    logic              rd_acc;
    logic [WIDTH-1:0]  ram_rdata;

    // Flags decode the registered count only, so acceptance of a write never
    // depends combinationally on read (and vice versa).
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_FULL);
    assign almost_empty = (count_q <= CNT_AE);
    assign almost_full  = (count_q >= CNT_AF);
    assign counter      = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign wr_acc = write && !full;
    assign rd_acc = read  && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = write && full;
        udf_d    = read  && empty;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram_2p #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out   = empty ? '0 : ram_rdata;
    assign data_valid = !empty;
`else
    logic dv_q, dv_d;

    assign dv_d = rd_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            dv_q <= 1'b0;
        end else begin
            dv_q <= dv_d;
        end
    end

    assign data_out   = ram_rdata;
    assign data_valid = dv_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at WIDTH=16, DEPTH=8, AF=6, AE=2.
module tb_sync_fifo_param;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;
    logic [CNT_W-1:0] counter;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .read         (read),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow),
        .counter      (counter)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] din;
        int          cnt;
        logic [15:0] dout;
        logic        dv;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t vecs [64];
    int   nvec = 0;

    task automatic add(input logic wr, input logic rd, input logic [15:0] din,
                       input int cnt, input logic [15:0] dout, input logic dv,
                       input logic ovf, input logic udf);
        vecs[nvec] = '{wr, rd, din, cnt, dout, dv, ovf, udf};
        nvec++;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the next rising edge.
    task automatic cycle(input logic rst, input logic wr, input logic rd,
                         input logic [15:0] din);
        @(negedge clk);
        reset   = rst;
        write   = wr;
        read    = rd;
        data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input int idx, input int cnt, input logic [15:0] dout,
                             input logic dv, input logic ovf, input logic udf);
        chk("counter",      idx, 32'(counter),      32'(cnt));
        chk("empty",        idx, 32'(empty),        32'(cnt == 0));
        chk("full",         idx, 32'(full),         32'(cnt == DEPTH));
        chk("almost_empty", idx, 32'(almost_empty), 32'(cnt <= 2));
        chk("almost_full",  idx, 32'(almost_full),  32'(cnt >= 6));
        chk("data_out",     idx, 32'(data_out),     32'(dout));
        chk("data_valid",   idx, 32'(data_valid),   32'(dv));
        chk("overflow",     idx, 32'(overflow),     32'(ovf));
        chk("underflow",    idx, 32'(underflow),    32'(udf));
    endtask

    initial begin
        reset   = 1'b1;
        write   = 1'b0;
        read    = 1'b0;
        data_in = '0;

        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        chk_state(-1, 0, 16'h0000, 1'b0, 1'b0, 1'b0);

`ifndef SYNC_FIFO_FWFT_EN
        // Fill with 1..8.
        for (int k = 1; k <= 8; k++) add(1, 0, 16'(k), k, 16'h0000, 0, 0, 0);
        // Write while full: dropped, overflow pulse.
        add(1, 0, 16'hDEAD, 8, 16'h0000, 0, 1, 0);
        add(0, 0, 16'h0000, 8, 16'h0000, 0, 0, 0);
        // Write+read while full: read only, write dropped.
        add(1, 1, 16'h00BA, 7, 16'h0001, 1, 1, 0);
        for (int k = 2; k <= 8; k++) add(0, 1, 16'h0000, 8 - k, 16'(k), 1, 0, 0);
        // Read while empty: underflow, data held, no valid.
        add(0, 1, 16'h0000, 0, 16'h0008, 0, 0, 1);
        add(0, 0, 16'h0000, 0, 16'h0008, 0, 0, 0);
        // Bring to 4 entries, then 10 simultaneous rd/wr across the wrap.
        for (int k = 1; k <= 4; k++) add(1, 0, 16'(16'h10 + k), k, 16'h0008, 0, 0, 0);
        for (int k = 0; k < 10; k++) add(1, 1, 16'(16'h15 + k), 4, 16'(16'h11 + k), 1, 0, 0);
        add(1, 0, 16'h001F, 5, 16'h001A, 0, 0, 0);

        for (int i = 0; i < nvec; i++) begin
            cycle(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk_state(i, vecs[i].cnt, vecs[i].dout, vecs[i].dv, vecs[i].ovf, vecs[i].udf);
        end

        // Reset at count 5 with write and read asserted: reset wins.
        cycle(1'b1, 1'b1, 1'b1, 16'hBEEF);
        chk_state(100, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0077);
        chk_state(101, 1, 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000);
        chk_state(102, 0, 16'h0077, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000);
        chk_state(103, 0, 16'h0077, 1'b0, 1'b0, 1'b1);
`else
        // First-word-fall-through: head word visible without a read.
        cycle(1'b0, 1'b1, 1'b0, 16'h00A5);
        chk_state(200, 1, 16'h00A5, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 16'h005A);
        chk_state(201, 2, 16'h00A5, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000);
        chk_state(202, 1, 16'h005A, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000);
        chk_state(203, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000);
        chk_state(204, 0, 16'h0000, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) cycle(1'b0, 1'b1, 1'b0, 16'(k));
        chk_state(205, 8, 16'h0001, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 16'hDEAD);
        chk_state(206, 7, 16'h0002, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 16'hBEEF);
        chk_state(207, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
